// File: rtl/board_pkg.sv
// Shared constants, types and palette for the board row server.
// BOARD_PALETTE_EN: store 3-bit piece IDs and map them through PALETTE on read.
package board_pkg;
    localparam int BOARD_W = 10;
    localparam int BOARD_H = 20;
    localparam int CELL_W  = 16;
    localparam int NCELLS  = BOARD_W * BOARD_H;
    localparam int ADDR_W  = 8;
`ifdef BOARD_PALETTE_EN
    localparam int RAM_W   = 3;
    localparam int RD_LAT  = 2;
`else
    localparam int RAM_W   = CELL_W;
    localparam int RD_LAT  = 1;
`endif
    localparam int CNT_W   = $clog2(BOARD_W + RD_LAT + 1);

    typedef logic [CELL_W-1:0] cell_t;
    typedef enum logic [1:0] {IDLE, FETCH, CLEAR} srv_state_t;

    localparam cell_t PALETTE [8] = '{16'h0000, 16'h0F00, 16'h00F0, 16'h000F,
                                      16'h0FF0, 16'h0F0F, 16'h00FF, 16'h0FFF};

    function automatic cell_t pal_map(input logic [2:0] id);
        return PALETTE[id];
    endfunction
endpackage

// File: rtl/board_row_if.sv
// Row-fetch, cell-write and clear signals between the game/display side and the board server.
interface board_row_if;
    import board_pkg::*;
    logic        LD_Row;
    logic [7:0]  rowNum;
    cell_t       Row [BOARD_W];
    logic        rowReady;
    logic        wr_en;
    logic [3:0]  wr_x;
    logic [4:0]  wr_y;
    cell_t       wr_data;
    logic        clear_req;
    logic        busy;

    modport master (output LD_Row, rowNum, wr_en, wr_x, wr_y, wr_data, clear_req,
                    input  Row, rowReady, busy);
    modport slave  (input  LD_Row, rowNum, wr_en, wr_x, wr_y, wr_data, clear_req,
                    output Row, rowReady, busy);
endinterface

// File: rtl/board_ram.sv
// Simple dual-port synchronous RAM, one write and one read port, read-before-write.
module board_ram #(
    parameter int DW    = 16,
    parameter int DEPTH = 200,
    parameter int AW    = 8
) (
    input  logic          Clk,
    input  logic          we,
    input  logic [AW-1:0] wa,
    input  logic [DW-1:0] wd,
    input  logic          re,
    input  logic [AW-1:0] ra,
    output logic [DW-1:0] rd
);
    logic [DW-1:0] mem [DEPTH];

    always_ff @(posedge Clk) begin
        if (we) mem[wa] <= wd;
        if (re) rd <= mem[ra];
    end
endmodule

// File: rtl/board_row_server.sv
// Board row server: holds the playfield, serves double-buffered row reads, cell writes, clear.
// BOARD_PALETTE_EN adds a palette lookup stage on the read path.
module board_row_server
    import board_pkg::*;
(
    input  logic      Clk,
    input  logic      reset_n,
    board_row_if.slave rif
);
    srv_state_t          state;
    logic                pending, clr_q, clr_susp, busy_q, ready_q;
    logic [7:0]          req_row, cur_row;
    logic [ADDR_W-1:0]   clr_addr;
    logic [CNT_W-1:0]    cnt, fill_idx;
    logic [RD_LAT:1]     vld_pipe;
    cell_t               shadow [BOARD_W];
    cell_t               shadow_nx [BOARD_W];
    cell_t               row_q [BOARD_W];
    cell_t               cell_d, fill_val;
    logic                row_ok, slot_vld, rd_en, done, take_req, clr_take;
    logic                game_we, ram_we;
    logic [ADDR_W-1:0]   rd_addr, ram_wa;
    logic [RAM_W-1:0]    ram_wd, rd_data;

    assign row_ok   = cur_row < 8'(BOARD_H);
    assign slot_vld = (state == FETCH) && (cnt < CNT_W'(BOARD_W));
    assign rd_en    = slot_vld && row_ok;
    assign rd_addr  = ADDR_W'(16'(cur_row) * 16'(BOARD_W) + 16'(cnt));
    assign done     = (state == FETCH) && (cnt == CNT_W'(BOARD_W + RD_LAT - 1));
    assign fill_idx = cnt - CNT_W'(RD_LAT);
    assign fill_val = row_ok ? cell_d : '0;

    // A waiting request is taken on any transition into FETCH; a suspended clear resumes first.
    assign take_req = pending && ((state == IDLE) || (state == CLEAR) || (done && !clr_susp));
    assign clr_take = (state == IDLE) && !pending && clr_q;

    assign game_we = rif.wr_en && !busy_q && (rif.wr_x < 4'(BOARD_W)) && (rif.wr_y < 5'(BOARD_H));
    assign ram_we  = (state == CLEAR) || game_we;
    assign ram_wa  = (state == CLEAR) ? clr_addr
                                      : ADDR_W'(8'(rif.wr_y) * 8'(BOARD_W) + 8'(rif.wr_x));
    assign ram_wd  = (state == CLEAR) ? '0 : rif.wr_data[RAM_W-1:0];

    board_ram #(.DW(RAM_W), .DEPTH(NCELLS), .AW(ADDR_W)) u_ram (
        .Clk (Clk),
        .we  (ram_we),
        .wa  (ram_wa),
        .wd  (ram_wd),
        .re  (rd_en),
        .ra  (rd_addr),
        .rd  (rd_data)
    );

`ifdef BOARD_PALETTE_EN
    cell_t pal_q;
    always_ff @(posedge Clk) pal_q <= pal_map(rd_data);
    assign cell_d = pal_q;
`else
    assign cell_d = rd_data;
`endif

    always_comb begin
        shadow_nx = shadow;
        if (vld_pipe[RD_LAT]) shadow_nx[fill_idx] = fill_val;
    end

    always_ff @(posedge Clk) shadow <= shadow_nx;

    always_ff @(posedge Clk) begin
        if (!reset_n) begin
            state    <= IDLE;
            pending  <= 1'b0;
            clr_q    <= 1'b0;
            clr_susp <= 1'b0;
            busy_q   <= 1'b0;
            ready_q  <= 1'b0;
            req_row  <= '0;
            cur_row  <= '0;
            clr_addr <= '0;
            cnt      <= '0;
            vld_pipe <= '0;
            for (int i = 0; i < BOARD_W; i++) row_q[i] <= '0;
        end else begin
            ready_q  <= 1'b0;
            vld_pipe <= (vld_pipe << 1) | RD_LAT'(slot_vld);
            pending  <= rif.LD_Row | (pending & ~take_req);
            clr_q    <= ~clr_take & (clr_q | (rif.clear_req & ~busy_q));
            if (rif.LD_Row) req_row <= rif.rowNum;

            case (state)
                IDLE: begin
                    if (pending) state <= FETCH;
                    else if (clr_q) begin
                        state    <= CLEAR;
                        clr_addr <= '0;
                        busy_q   <= 1'b1;
                    end
                end
                FETCH: begin
                    if (done) begin
                        row_q   <= shadow_nx;
                        ready_q <= 1'b1;
                        if (clr_susp) begin
                            state    <= CLEAR;
                            clr_susp <= 1'b0;
                        end else if (pending) state <= FETCH;
                        else state <= IDLE;
                    end else cnt <= cnt + 1'b1;
                end
                CLEAR: begin
                    if (clr_addr == ADDR_W'(NCELLS - 1)) begin
                        busy_q <= 1'b0;
                        state  <= pending ? FETCH : IDLE;
                    end else begin
                        clr_addr <= clr_addr + 1'b1;
                        if (pending) begin
                            clr_susp <= 1'b1;
                            state    <= FETCH;
                        end
                    end
                end
                default: state <= IDLE;
            endcase

            if (take_req) begin
                cur_row <= req_row;
                cnt     <= '0;
            end
        end
    end

    assign rif.Row      = row_q;
    assign rif.rowReady = ready_q;
    assign rif.busy     = busy_q;
endmodule

// File: tb/tb_board_row_server.sv
// Directed + randomized bench for board_row_server against a 2-D array model of the board.
module tb_board_row_server;
    import board_pkg::*;

`ifdef BOARD_PALETTE_EN
    localparam int LAT = 13;
`else
    localparam int LAT = 12;
`endif

    logic Clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 Clk = ~Clk;

    board_row_if rif();
    board_row_server dut (.Clk(Clk), .reset_n(reset_n), .rif(rif.slave));

    int total = 0;
    int bad = 0;
    logic [15:0] model [BOARD_H][BOARD_W];

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] exp_cell(input int y, input int x);
        if (y >= BOARD_H) return 16'h0;
`ifdef BOARD_PALETTE_EN
        return PALETTE[model[y][x][2:0]];
`else
        return model[y][x];
`endif
    endfunction

    task automatic model_clear();
        for (int y = 0; y < BOARD_H; y++)
            for (int x = 0; x < BOARD_W; x++) model[y][x] = 16'h0;
    endtask

    // Drives one write; the model only takes it when the server is expected to accept it.
    task automatic wr(input int x, input int y, input logic [15:0] d, input bit accept);
        rif.wr_x = 4'(x); rif.wr_y = 5'(y); rif.wr_data = d; rif.wr_en = 1'b1;
        step();
        rif.wr_en = 1'b0;
        if (accept && x < BOARD_W && y < BOARD_H) model[y][x] = d;
    endtask

    task automatic wait_ready(output int lat);
        lat = -1;
        for (int k = 1; k <= 40; k++) begin
            step();
            if (rif.rowReady) begin lat = k; break; end
        end
    endtask

    task automatic check_row(input string tag, input int r);
        for (int x = 0; x < BOARD_W; x++)
            chk($sformatf("%s_x%0d", tag, x), 32'(rif.Row[x]), 32'(exp_cell(r, x)));
    endtask

    task automatic do_read(input string tag, input int r);
        int lat;
        rif.rowNum = 8'(r); rif.LD_Row = 1'b1;
        step();
        rif.LD_Row = 1'b0;
        wait_ready(lat);
        chk({tag, "_lat"}, 32'(lat), 32'(LAT));
        check_row(tag, r);
        step();
        chk({tag, "_pulse"}, 32'(rif.rowReady), 32'd0);
    endtask

    task automatic wait_clear(input string tag, output int cycles);
        cycles = 0;
        for (int k = 0; k < 600; k++) begin
            step();
            if (rif.busy) cycles++;
            else if (cycles > 0) break;
        end
        chk({tag, "_idle"}, 32'(rif.busy), 32'd0);
    endtask

    initial begin
        int lat, lat2, cyc, pulses;
        rif.LD_Row = 0; rif.rowNum = 0; rif.wr_en = 0; rif.wr_x = 0; rif.wr_y = 0;
        rif.wr_data = 0; rif.clear_req = 0;
        repeat (2) step();
        chk("rst_ready", 32'(rif.rowReady), 0);
        chk("rst_busy", 32'(rif.busy), 0);
        for (int x = 0; x < BOARD_W; x++) chk($sformatf("rst_row%0d", x), 32'(rif.Row[x]), 0);
        reset_n = 1'b1;
        step();

        // Full clear gives the model a known board.
        rif.clear_req = 1'b1; step(); rif.clear_req = 1'b0;
        wait_clear("clr0", cyc);
        chk("clr0_cycles", 32'(cyc), 32'(NCELLS));
        model_clear();

        wr(3, 5, 16'h0F00, 1'b1);
        do_read("t1", 5);
        do_read("t2", 25);

        for (int i = 0; i < 40; i++)
            wr($urandom_range(0, 11), $urandom_range(0, 21), 16'($urandom), 1'b1);
        for (int i = 0; i < 12; i++)
            do_read($sformatf("rnd%0d", i), $urandom_range(0, 24));

        // Clear with a write attempt while busy and a row served mid-clear.
        for (int x = 0; x < BOARD_W; x++) wr(x, 19, 16'(16'h0A00 + x + 1), 1'b1);
        rif.clear_req = 1'b1; step(); rif.clear_req = 1'b0;
        repeat (10) step();
        chk("t4_busy", 32'(rif.busy), 1);
        wr(2, 7, 16'h1234, 1'b0);
        repeat (40) step();
        rif.rowNum = 8'd19; rif.LD_Row = 1'b1; step(); rif.LD_Row = 1'b0;
        wait_ready(lat);
        chk("t4_lat", 32'(lat), 32'(LAT));
        check_row("t4_row19", 19);
        chk("t4_busy_mid", 32'(rif.busy), 1);
        wait_clear("t4", cyc);
        model_clear();
        do_read("t4_r0", 0);
        do_read("t4_r7", 7);
        do_read("t4_r19", 19);

        // Newest request arriving during a fetch is served right after.
        wr(0, 1, 16'h0111, 1'b1);
        wr(4, 2, 16'h0222, 1'b1);
        rif.rowNum = 8'd1; rif.LD_Row = 1'b1; step(); rif.LD_Row = 1'b0;
        repeat (4) step();
        rif.rowNum = 8'd2; rif.LD_Row = 1'b1; step(); rif.LD_Row = 1'b0;
        wait_ready(lat);
        chk("t3_lat1", 32'(lat), 32'(LAT - 5));
        check_row("t3_row1", 1);
        wait_ready(lat2);
        chk("t3_gap", 32'(lat2), 32'(LAT - 1));
        check_row("t3_row2", 2);

        // Reset in the middle of a fetch drops the request.
        rif.rowNum = 8'd1; rif.LD_Row = 1'b1; step(); rif.LD_Row = 1'b0;
        repeat (5) step();
        reset_n = 1'b0; step(); reset_n = 1'b1;
        chk("t5_ready", 32'(rif.rowReady), 0);
        chk("t5_busy", 32'(rif.busy), 0);
        for (int x = 0; x < BOARD_W; x++) chk($sformatf("t5_row%0d", x), 32'(rif.Row[x]), 0);
        pulses = 0;
        for (int k = 0; k < 20; k++) begin
            step();
            if (rif.rowReady) pulses++;
        end
        chk("t5_no_ready", 32'(pulses), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
